// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory-access unit: access sizes, FSM states and data-bus structs.
// Bus structs are sized for the widest (64-bit) build; narrower builds leave the upper bits zero.
package mem_access_unit_pkg;

  localparam int BUS_W      = 64;
  localparam int BUS_STRB_W = BUS_W / 8;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    LOAD,
    DONE
  } mau_state_t;

  typedef struct packed {
    logic [BUS_W-1:0]      addr;
    msize_t                size;
    logic [BUS_STRB_W-1:0] strobe;
    logic [BUS_W-1:0]      data;
  } sb_entry_t;

  typedef struct packed {
    logic                  valid;
    logic [BUS_W-1:0]      addr;
    msize_t                size;
    logic [BUS_STRB_W-1:0] strobe;
    logic [BUS_W-1:0]      data;
  } dbus_req_t;

  typedef struct packed {
    logic             addr_ok;
    logic             data_ok;
    logic [BUS_W-1:0] data;
  } dbus_resp_t;

  // Byte count of an access; unknown encodings report 0 so callers can flag them illegal.
  function automatic int size_bytes(msize_t s);
    case (s)
      MSIZE1:  return 1;
      MSIZE2:  return 2;
      MSIZE4:  return 4;
      MSIZE8:  return 8;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/mau_store_fifo.sv
// Circular store buffer: stores retire into it and the access FSM drains it in order.
// Simultaneous push and pop are legal even when full; the popped slot is the one refilled.
module mau_store_fifo
  import mem_access_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  sb_entry_t                entry_i,
  input  logic                     pop_i,
  output sb_entry_t                head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  sb_entry_t        mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == DEPTH[PW:0]);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access engine: buffers stores, drains them to the data bus, issues loads
// once the buffer is empty, and aligns/extends load data for writeback.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int SB_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              op_valid_i,
  input  logic              op_load_i,
  input  logic              op_store_i,
  input  msize_t            op_size_i,
  input  logic              op_zext_i,
  input  logic [DATA_W-1:0] op_addr_i,
  input  logic [DATA_W-1:0] op_wdata_i,
  input  logic [DATA_W-1:0] alu_res_i,
  output logic              stall_o,
  output logic              res_valid_o,
  output logic [DATA_W-1:0] result_o,
  output logic              misalign_o,
  output dbus_req_t         dreq_o,
  input  dbus_resp_t        dresp_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int CW     = $clog2(SB_DEPTH) + 1;

  function automatic logic [STRB_W-1:0] size_mask(msize_t s);
    logic [STRB_W-1:0] m;
    m = '0;
    for (int i = 0; i < STRB_W; i++) m[i] = (i < size_bytes(s));
    return m;
  endfunction

  // Keep the selected bytes and fill above them with the top kept bit unless zero-extending.
  function automatic logic [DATA_W-1:0] extend(logic [DATA_W-1:0] raw, logic [STRB_W-1:0] bm,
                                               logic zext);
    logic [DATA_W-1:0] keep;
    logic              sgn;
    keep = '0;
    sgn  = 1'b0;
    for (int i = 0; i < STRB_W; i++) begin
      if (bm[i]) begin
        keep[8*i +: 8] = 8'hFF;
        sgn            = raw[8*i+7];
      end
    end
    return (raw & keep) | ((sgn & ~zext) ? ~keep : '0);
  endfunction

  mau_state_t        state_q, state_d;
  logic [DATA_W-1:0] ld_addr_q, ld_addr_d;
  msize_t            ld_size_q, ld_size_d;
  logic              ld_zext_q, ld_zext_d;
  logic [DATA_W-1:0] ld_data_q, ld_data_d;

  sb_entry_t         sb_in, sb_head;
  logic              sb_push, sb_pop, sb_full, sb_empty;
  logic [CW-1:0]     sb_count;

  logic [OFF_W-1:0]  op_off, align_mask;
  logic [STRB_W-1:0] op_strb, ld_strb;
  logic [DATA_W-1:0] ld_raw;
  logic              op_bad, ld_ok, st_ok, accepting, hs;
  int                op_bytes;

  // Decode the execute op: legality, lane placement and the entry it would enqueue.
  always_comb begin
    op_bytes   = size_bytes(op_size_i);
    op_off     = op_addr_i[OFF_W-1:0];
    align_mask = OFF_W'(op_bytes - 1);
    op_bad     = (op_load_i & op_store_i) | (op_bytes == 0) | (op_bytes > STRB_W) |
                 (|(op_off & align_mask));
    ld_ok      = op_valid_i & op_load_i & ~op_bad;
    st_ok      = op_valid_i & op_store_i & ~op_bad;
    op_strb    = size_mask(op_size_i) << op_off;

    sb_in        = '0;
    sb_in.addr   = BUS_W'(op_addr_i);
    sb_in.size   = op_size_i;
    sb_in.strobe = BUS_STRB_W'(op_strb);
    sb_in.data   = BUS_W'(op_wdata_i << {op_off, 3'b000});

    ld_strb = size_mask(ld_size_q) << ld_addr_q[OFF_W-1:0];
    ld_raw  = dresp_i.data[DATA_W-1:0] >> {ld_addr_q[OFF_W-1:0], 3'b000};
  end

  assign hs        = dresp_i.addr_ok & dresp_i.data_ok;
  assign accepting = (state_q == IDLE) || (state_q == DRAIN);
  assign sb_pop    = (state_q == DRAIN) & hs;
  assign sb_push   = accepting & st_ok & (~sb_full | sb_pop);

  mau_store_fifo #(
    .DEPTH (SB_DEPTH)
  ) u_store_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (sb_push),
    .entry_i (sb_in),
    .pop_i   (sb_pop),
    .head_o  (sb_head),
    .full_o  (sb_full),
    .empty_o (sb_empty),
    .count_o (sb_count)
  );

  // Next state and pipeline-facing outputs; ops are only consumed in IDLE and DRAIN.
  always_comb begin
    state_d     = state_q;
    ld_addr_d   = ld_addr_q;
    ld_size_d   = ld_size_q;
    ld_zext_d   = ld_zext_q;
    ld_data_d   = ld_data_q;
    stall_o     = 1'b0;
    res_valid_o = 1'b0;
    result_o    = '0;
    misalign_o  = 1'b0;

    if (accepting) begin
      misalign_o = op_valid_i & (op_load_i | op_store_i) & op_bad;
      if (st_ok) begin
        stall_o     = ~sb_push;
        res_valid_o = sb_push;
        result_o    = sb_push ? alu_res_i : '0;
      end else if (ld_ok) begin
        stall_o = 1'b1;
      end else if (op_valid_i && !op_load_i && !op_store_i) begin
        res_valid_o = 1'b1;
        result_o    = alu_res_i;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (!sb_empty) begin
          state_d = DRAIN;
        end else if (ld_ok) begin
          state_d   = LOAD;
          ld_addr_d = op_addr_i;
          ld_size_d = op_size_i;
          ld_zext_d = op_zext_i;
        end
      end
      DRAIN: begin
        if (sb_pop && !sb_push && sb_count == CW'(1)) state_d = IDLE;
      end
      LOAD: begin
        stall_o = 1'b1;
        if (hs) begin
          state_d   = DONE;
          ld_data_d = extend(ld_raw, size_mask(ld_size_q), ld_zext_q);
        end
      end
      DONE: begin
        res_valid_o = 1'b1;
        result_o    = ld_data_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The request is a pure function of registered state, so it stays bit-stable until handshake.
  always_comb begin
    dreq_o = '0;
    if (state_q == DRAIN) begin
      dreq_o.valid  = 1'b1;
      dreq_o.addr   = sb_head.addr;
      dreq_o.size   = sb_head.size;
      dreq_o.strobe = sb_head.strobe;
      dreq_o.data   = sb_head.data;
    end else if (state_q == LOAD) begin
      dreq_o.valid  = 1'b1;
      dreq_o.addr   = BUS_W'(ld_addr_q);
      dreq_o.size   = ld_size_q;
      dreq_o.strobe = BUS_STRB_W'(ld_strb);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      ld_addr_q <= '0;
      ld_size_q <= MSIZE1;
      ld_zext_q <= 1'b0;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ld_addr_q <= ld_addr_d;
      ld_size_q <= ld_size_d;
      ld_zext_q <= ld_zext_d;
      ld_data_q <= ld_data_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: inputs change on the falling edge, outputs are
// compared 1 time unit later against hand-computed values.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        opValid, opLoad, opStore, opZext;
  msize_t      opSize;
  logic [63:0] opAddr, opWdata, aluRes;
  logic        stall, resValid, misalign;
  logic [63:0] result;
  dbus_req_t   dreq;
  dbus_resp_t  dresp;

  int checks   = 0;
  int failures = 0;

  mem_access_unit #(
    .DATA_W   (64),
    .SB_DEPTH (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .op_valid_i  (opValid),
    .op_load_i   (opLoad),
    .op_store_i  (opStore),
    .op_size_i   (opSize),
    .op_zext_i   (opZext),
    .op_addr_i   (opAddr),
    .op_wdata_i  (opWdata),
    .alu_res_i   (aluRes),
    .stall_o     (stall),
    .res_valid_o (resValid),
    .result_o    (result),
    .misalign_o  (misalign),
    .dreq_o      (dreq),
    .dresp_i     (dresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, ld, st, input msize_t sz, input logic zx,
                               input logic [63:0] addr, wdata, alu,
                               input logic aok, dok, input logic [63:0] rdata);
    @(negedge clk);
    opValid = v;  opLoad = ld;  opStore = st;  opSize = sz;  opZext = zx;
    opAddr = addr;  opWdata = wdata;  aluRes = alu;
    dresp.addr_ok = aok;  dresp.data_ok = dok;  dresp.data = rdata;
    #1;
  endtask

  task automatic idleCycle(input logic aok, dok, input logic [63:0] rdata);
    applyStimulus(1'b0, 1'b0, 1'b0, MSIZE1, 1'b0, 64'h0, 64'h0, 64'h0, aok, dok, rdata);
  endtask

  task automatic doLoad(input string tag, input msize_t sz, input logic zx,
                        input logic [63:0] addr, rdata, expected);
    applyStimulus(1'b1, 1'b1, 1'b0, sz, zx, addr, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    checkOutput({tag, "-issue-stall"}, stall, 1'b1);
    checkOutput({tag, "-issue-misalign"}, misalign, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, sz, zx, addr, 64'h0, 64'h0, 1'b1, 1'b1, rdata);
    checkOutput({tag, "-req-valid"}, dreq.valid, 1'b1);
    checkOutput({tag, "-req-addr"}, dreq.addr, addr);
    applyStimulus(1'b1, 1'b1, 1'b0, sz, zx, addr, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    checkOutput({tag, "-done-valid"}, resValid, 1'b1);
    checkOutput({tag, "-done-stall"}, stall, 1'b0);
    checkOutput({tag, "-result"}, result, expected);
  endtask

  localparam logic [63:0] MEM_WORD = 64'h8877665544332211;

  initial begin
    string       ldTag [6]  = '{"lb3", "lb7", "lbu7", "lh6", "ld0", "lwu4"};
    msize_t      ldSize[6]  = '{MSIZE1, MSIZE1, MSIZE1, MSIZE2, MSIZE8, MSIZE4};
    logic        ldZext[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [63:0] ldAddr[6]  = '{64'h1003, 64'h1007, 64'h1007, 64'h1006, 64'h1000, 64'h1004};
    logic [63:0] ldExp [6]  = '{64'h44, 64'hFFFF_FFFF_FFFF_FF88, 64'h88, 64'hFFFF_FFFF_FFFF_8877,
                                64'h8877665544332211, 64'h88776655};
    logic [63:0] drainAddr[4] = '{64'h208, 64'h210, 64'h218, 64'h220};

    rst_n = 1'b0;
    opValid = 1'b0;  opLoad = 1'b0;  opStore = 1'b0;  opSize = MSIZE1;  opZext = 1'b0;
    opAddr = '0;  opWdata = '0;  aluRes = '0;  dresp = '0;

    // Reset state
    #12;
    checkOutput("rst-stall", stall, 1'b0);
    checkOutput("rst-resvalid", resValid, 1'b0);
    checkOutput("rst-misalign", misalign, 1'b0);
    checkOutput("rst-result", result, 64'h0);
    checkOutput("rst-dreq-valid", dreq.valid, 1'b0);
    checkOutput("rst-dreq-addr", dreq.addr, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Non-memory op passes alu_res straight through
    applyStimulus(1'b1, 1'b0, 1'b0, MSIZE1, 1'b0, 64'h0, 64'h0, 64'h1234, 1'b0, 1'b0, 64'h0);
    checkOutput("alu-resvalid", resValid, 1'b1);
    checkOutput("alu-result", result, 64'h1234);
    checkOutput("alu-stall", stall, 1'b0);

    // Load alignment / extension table
    for (int i = 0; i < 6; i++) doLoad(ldTag[i], ldSize[i], ldZext[i], ldAddr[i], MEM_WORD, ldExp[i]);

    // SD retires immediately, then drains with the request held across a stalled bus
    applyStimulus(1'b1, 1'b0, 1'b1, MSIZE8, 1'b0, 64'h100, 64'h1122334455667788, 64'h0,
                  1'b0, 1'b0, 64'h0);
    checkOutput("sd-stall", stall, 1'b0);
    checkOutput("sd-resvalid", resValid, 1'b1);
    idleCycle(1'b0, 1'b0, 64'h0);
    checkOutput("sd-idle-req", dreq.valid, 1'b0);
    idleCycle(1'b0, 1'b0, 64'h0);
    checkOutput("sd-drain-valid", dreq.valid, 1'b1);
    checkOutput("sd-drain-strobe", dreq.strobe, 8'hFF);
    checkOutput("sd-drain-addr", dreq.addr, 64'h100);
    checkOutput("sd-drain-data", dreq.data, 64'h1122334455667788);
    idleCycle(1'b0, 1'b1, 64'h0);
    checkOutput("sd-hold1-data", dreq.data, 64'h1122334455667788);
    checkOutput("sd-hold1-valid", dreq.valid, 1'b1);
    idleCycle(1'b0, 1'b0, 64'h0);
    checkOutput("sd-hold2-data", dreq.data, 64'h1122334455667788);
    idleCycle(1'b1, 1'b1, 64'h0);
    checkOutput("sd-hs-valid", dreq.valid, 1'b1);
    idleCycle(1'b0, 1'b0, 64'h0);
    checkOutput("sd-after-valid", dreq.valid, 1'b0);

    // Fill the buffer with the bus stalled, then free one slot
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, MSIZE8, 1'b0, 64'h200 + 64'(8 * k), 64'(k + 1), 64'h0,
                    1'b0, 1'b0, 64'h0);
      checkOutput($sformatf("fill%0d-stall", k), stall, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, MSIZE8, 1'b0, 64'h220, 64'd5, 64'h0, 1'b0, 1'b0, 64'h0);
    checkOutput("full-stall", stall, 1'b1);
    checkOutput("full-resvalid", resValid, 1'b0);
    checkOutput("full-head-addr", dreq.addr, 64'h200);
    applyStimulus(1'b1, 1'b0, 1'b1, MSIZE8, 1'b0, 64'h220, 64'd5, 64'h0, 1'b0, 1'b0, 64'h0);
    checkOutput("full-hold-stall", stall, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, MSIZE8, 1'b0, 64'h220, 64'd5, 64'h0, 1'b1, 1'b1, 64'h0);
    checkOutput("freeing-stall", stall, 1'b0);
    checkOutput("freeing-resvalid", resValid, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, MSIZE8, 1'b0, 64'h228, 64'd6, 64'h0, 1'b0, 1'b0, 64'h0);
    checkOutput("still-full-stall", stall, 1'b1);
    checkOutput("still-full-head", dreq.addr, 64'h208);
    for (int k = 0; k < 4; k++) begin
      idleCycle(1'b1, 1'b1, 64'h0);
      checkOutput($sformatf("drain%0d-valid", k), dreq.valid, 1'b1);
      checkOutput($sformatf("drain%0d-addr", k), dreq.addr, drainAddr[k]);
      checkOutput($sformatf("drain%0d-data", k), dreq.data, 64'(k + 2));
    end
    idleCycle(1'b0, 1'b0, 64'h0);
    checkOutput("drained-valid", dreq.valid, 1'b0);

    // SW then LW to the same address: load waits for the store to drain
    applyStimulus(1'b1, 1'b0, 1'b1, MSIZE4, 1'b0, 64'h204, 64'hDEADBEEF, 64'h0, 1'b0, 1'b0, 64'h0);
    checkOutput("sw-stall", stall, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, MSIZE4, 1'b0, 64'h204, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    checkOutput("lw-wait-stall", stall, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, MSIZE4, 1'b0, 64'h204, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    checkOutput("sw-drain-valid", dreq.valid, 1'b1);
    checkOutput("sw-drain-strobe", dreq.strobe, 8'hF0);
    checkOutput("sw-drain-data", dreq.data, 64'hDEADBEEF_00000000);
    checkOutput("lw-drain-stall", stall, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, MSIZE4, 1'b0, 64'h204, 64'h0, 64'h0, 1'b1, 1'b1, 64'h0);
    checkOutput("lw-hs-stall", stall, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, MSIZE4, 1'b0, 64'h204, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    checkOutput("lw-idle-valid", dreq.valid, 1'b0);
    checkOutput("lw-idle-stall", stall, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, MSIZE4, 1'b0, 64'h204, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    checkOutput("lw-req-valid", dreq.valid, 1'b1);
    checkOutput("lw-req-strobe", dreq.strobe, 8'hF0);
    applyStimulus(1'b1, 1'b1, 1'b0, MSIZE4, 1'b0, 64'h204, 64'h0, 64'h0, 1'b1, 1'b1,
                  64'hDEADBEEF_00000000);
    checkOutput("lw-hs-stall", stall, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, MSIZE4, 1'b0, 64'h204, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    checkOutput("lw-done-valid", resValid, 1'b1);
    checkOutput("lw-result", result, 64'hFFFF_FFFF_DEAD_BEEF);

    // Misaligned and illegal ops are dropped without touching the bus or buffer
    applyStimulus(1'b1, 1'b1, 1'b0, MSIZE2, 1'b0, 64'h101, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    checkOutput("lh-mis-flag", misalign, 1'b1);
    checkOutput("lh-mis-stall", stall, 1'b0);
    checkOutput("lh-mis-resvalid", resValid, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, MSIZE4, 1'b0, 64'h102, 64'h55, 64'h0, 1'b0, 1'b0, 64'h0);
    checkOutput("sw-mis-flag", misalign, 1'b1);
    checkOutput("sw-mis-stall", stall, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, MSIZE8, 1'b0, 64'h100, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    checkOutput("ldst-flag", misalign, 1'b1);
    idleCycle(1'b0, 1'b0, 64'h0);
    checkOutput("mis-clear", misalign, 1'b0);
    checkOutput("mis-req1", dreq.valid, 1'b0);
    idleCycle(1'b0, 1'b0, 64'h0);
    checkOutput("mis-req2", dreq.valid, 1'b0);

    // Reset while a load waits on the bus
    applyStimulus(1'b1, 1'b1, 1'b0, MSIZE8, 1'b0, 64'h300, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, MSIZE8, 1'b0, 64'h300, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    checkOutput("rstld-pre-valid", dreq.valid, 1'b1);
    #2;
    rst_n = 1'b0;
    opValid = 1'b0;
    #1;
    checkOutput("rstld-valid", dreq.valid, 1'b0);
    checkOutput("rstld-stall", stall, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while draining: the buffered store must be discarded
    applyStimulus(1'b1, 1'b0, 1'b1, MSIZE8, 1'b0, 64'h400, 64'h77, 64'h0, 1'b0, 1'b0, 64'h0);
    idleCycle(1'b0, 1'b0, 64'h0);
    idleCycle(1'b0, 1'b0, 64'h0);
    checkOutput("rstsb-pre-addr", dreq.addr, 64'h400);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstsb-valid", dreq.valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idleCycle(1'b0, 1'b0, 64'h0);
    checkOutput("rstsb-after1", dreq.valid, 1'b0);
    idleCycle(1'b0, 1'b0, 64'h0);
    checkOutput("rstsb-after2", dreq.valid, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, MSIZE8, 1'b0, 64'h500, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, MSIZE8, 1'b0, 64'h500, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    checkOutput("rstsb-load-addr", dreq.addr, 64'h500);
    idleCycle(1'b0, 1'b0, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
